// File: rtl/pll_cen_if.sv
// Control/status bundle for the fractional clock-enable generator.
// Master drives run/retune requests; slave returns the enables and lock status.
interface pll_cen_if #(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              en;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [NUM_CH-1:0] outclk_cen;
  logic [NUM_CH-1:0] outclk_sq;
  logic              locked;

  modport master (
    output en, cfg_wr, cfg_ch, cfg_inc,
    input  outclk_cen, outclk_sq, locked
  );

  modport slave (
    input  en, cfg_wr, cfg_ch, cfg_inc,
    output outclk_cen, outclk_sq, locked
  );
endinterface

// File: rtl/pll_cen_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per
// channel, f_out = f_ref * inc / 2^ACC_W, gated by an enable/settle/lock sequencer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | en low; accumulators and outputs held at 0, counter cleared
//   ST_SETTLE | counting settle edges; outputs held at 0, locked low
//   ST_LOCKED | accumulators running, enables/square outputs valid
module pll_cen_gen #(
  parameter int                      NUM_CH      = 3,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {32'h0, 32'h0, 32'h6666_6666}
) (
  input logic      refclk,
  input logic      rst_n,
  pll_cen_if.slave bus
);
  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W-1:0]  inc [NUM_CH];
  logic [ACC_W:0]    sum [NUM_CH];
  logic [NUM_CH-1:0] cen_q;
  logic [NUM_CH-1:0] sq_q;
  logic              locked_q;
  logic              cfg_hit;

  // Writes aimed past the last channel are dropped without disturbing lock.
  assign cfg_hit = bus.cfg_wr && ({1'b0, bus.cfg_ch} < NUM_CH_L);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
    assign sum[g] = {1'b0, acc[g]} + {1'b0, inc[g]};
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      locked_q <= 1'b0;
      cen_q    <= '0;
      sq_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit && (bus.cfg_ch == CH_W'(i))) inc[i] <= bus.cfg_inc;
      end

      if (!bus.en) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        locked_q <= 1'b0;
        cen_q    <= '0;
        sq_q     <= '0;
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else if (cfg_hit && (state != ST_IDLE)) begin
        // Retune restarts every channel from phase 0 so they stay aligned.
        state    <= ST_SETTLE;
        cnt      <= '0;
        locked_q <= 1'b0;
        cen_q    <= '0;
        sq_q     <= '0;
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            // The edge leaving IDLE is the first counted settle edge.
            state <= ST_SETTLE;
            cnt   <= CNT_W'(1);
          end
          ST_SETTLE: begin
            if (cnt == CNT_LAST) begin
              state    <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_LOCKED: begin
            for (int i = 0; i < NUM_CH; i++) begin
              acc[i]   <= sum[i][ACC_W-1:0];
              cen_q[i] <= sum[i][ACC_W];
              sq_q[i]  <= sum[i][ACC_W-1];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.outclk_cen = cen_q;
  assign bus.outclk_sq  = sq_q;
  assign bus.locked     = locked_q;
endmodule

// File: tb/tb_pll_cen_gen.sv
// Scoreboard bench for pll_cen_gen: stimulus queues the expected outputs of each
// edge, a monitor on the falling edge pops and compares them.
module tb_pll_cen_gen;
  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 4;

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;

  pll_cen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

  pll_cen_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .INC_INIT   ({8'h00, 8'h40, 8'h80})
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int         cyc;
    int         tag;
    logic       locked;
    logic [2:0] cen;
    logic [2:0] sq;
  } exp_t;

  exp_t       sb[$];
  int         pulses[$];
  int         edge_cnt = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         k_lock   = 0;
  int         lock_edge = 0;
  bit         rec_ch0  = 1'b0;
  logic [7:0] exp_inc [3];

  always @(posedge refclk) edge_cnt++;

  // Monitor: compare whatever the stimulus expected for the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
        e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_vec tag=%0d cyc=%0d now=%0d", e.tag, e.cyc, edge_cnt);
      end
      if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
        e = sb.pop_front();
        n_tests++;
        if (bus.locked !== e.locked || bus.outclk_cen !== e.cen || bus.outclk_sq !== e.sq) begin
          n_fail++;
          $display("FAIL vec tag=%0d cyc=%0d got locked=%b cen=%b sq=%b exp locked=%b cen=%b sq=%b",
                   e.tag, e.cyc, bus.locked, bus.outclk_cen, bus.outclk_sq,
                   e.locked, e.cen, e.sq);
        end
      end
      if (rec_ch0 && bus.outclk_cen[0] === 1'b1) pulses.push_back(edge_cnt);
    end
  end

  task automatic check(string nm, int got, int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
    end
  endtask

  task automatic tick_exp(int tag, logic lk, logic [2:0] c, logic [2:0] s);
    exp_t e;
    e.cyc    = edge_cnt + 1;
    e.tag    = tag;
    e.locked = lk;
    e.cen    = c;
    e.sq     = s;
    sb.push_back(e);
    @(posedge refclk);
    #1;
    bus.cfg_wr = 1'b0;
  endtask

  task automatic cfg(logic [1:0] ch, logic [7:0] v);
    bus.cfg_wr  = 1'b1;
    bus.cfg_ch  = ch;
    bus.cfg_inc = v;
  endtask

  // Three settle edges with outputs quiet, then the edge that raises locked.
  task automatic lock_seq(int tag);
    repeat (3) tick_exp(tag, 1'b0, 3'b000, 3'b000);
    tick_exp(tag, 1'b1, 3'b000, 3'b000);
    k_lock    = 0;
    lock_edge = edge_cnt;
  endtask

  // k-th locked edge: acc = k*inc mod 256; carry when floor(k*inc/256) steps.
  task automatic run_locked(int tag, int n);
    logic [2:0] c;
    logic [2:0] s;
    longint     p;
    longint     q;
    for (int j = 0; j < n; j++) begin
      k_lock++;
      for (int ch = 0; ch < 3; ch++) begin
        p     = longint'(k_lock) * longint'(exp_inc[ch]);
        q     = longint'(k_lock - 1) * longint'(exp_inc[ch]);
        c[ch] = ((p >> 8) != (q >> 8));
        s[ch] = p[7];
      end
      tick_exp(tag, 1'b1, c, s);
    end
  endtask

  initial begin
    logic [6:0] outs;
    bus.en      = 1'b0;
    bus.cfg_wr  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_inc = '0;
    exp_inc     = '{8'h80, 8'h40, 8'h00};

    // 1: reset then lock
    #1 rst_n = 1'b0;
    #2;
    outs = {bus.locked, bus.outclk_cen, bus.outclk_sq};
    check("reset_outputs", int'(outs), 0);
    tick_exp(1, 1'b0, 3'b000, 3'b000);
    tick_exp(1, 1'b0, 3'b000, 3'b000);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    lock_seq(1);

    // 2: reset-time rates (ch0 /2, ch1 /4, ch2 off)
    run_locked(2, 8);

    // 3: fractional ch0 inc=3 -> pulses at locked edges 86,171,256,342
    cfg(2'd0, 8'h03);
    exp_inc[0] = 8'h03;
    tick_exp(3, 1'b0, 3'b000, 3'b000);
    lock_seq(3);
    pulses.delete();
    rec_ch0 = 1'b1;
    run_locked(3, 342);
    @(negedge refclk);
    #1;
    rec_ch0 = 1'b0;
    check("frac_pulse_count", pulses.size(), 4);
    if (pulses.size() == 4) begin
      check("frac_first_pulse", pulses[0] - lock_edge, 86);
      check("frac_gap0", pulses[1] - pulses[0], 85);
      check("frac_gap1", pulses[2] - pulses[1], 85);
      check("frac_gap2", pulses[3] - pulses[2], 86);
    end

    // 4: retune ch1 while locked, then an out-of-range write
    cfg(2'd1, 8'h20);
    exp_inc[1] = 8'h20;
    tick_exp(4, 1'b0, 3'b000, 3'b000);
    lock_seq(4);
    run_locked(4, 8);
    cfg(2'd3, 8'hFF);
    run_locked(4, 16);

    // 5: en drop with a simultaneous write; new ch2 rate survives IDLE
    bus.en = 1'b0;
    cfg(2'd2, 8'h10);
    exp_inc[2] = 8'h10;
    tick_exp(5, 1'b0, 3'b000, 3'b000);
    tick_exp(5, 1'b0, 3'b000, 3'b000);
    tick_exp(5, 1'b0, 3'b000, 3'b000);
    bus.en = 1'b1;
    lock_seq(5);
    run_locked(5, 16);

    // 6: async reset between edges while ch1/ch2 are pulsing
    @(negedge refclk);
    #1;
    outs = {bus.locked, bus.outclk_cen, bus.outclk_sq};
    rst_n  = 1'b0;
    bus.en = 1'b0;
    #1;
    check("pre_reset_busy", int'(outs != 7'd0), 1);
    outs = {bus.locked, bus.outclk_cen, bus.outclk_sq};
    check("async_reset_outputs", int'(outs), 0);
    exp_inc = '{8'h80, 8'h40, 8'h00};
    tick_exp(6, 1'b0, 3'b000, 3'b000);
    tick_exp(6, 1'b0, 3'b000, 3'b000);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    lock_seq(6);
    run_locked(6, 8);

    @(negedge refclk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
